ccm_ctr_xor: RTL and testbench



---
 rtl/ccm_pkg.sv | 28 ++
 rtl/ccm_sync_fifo.sv | 58 +++++
 rtl/ccm_ctr_xor.sv | 124 ++++++++++++
 tb/tb_ccm_ctr_xor.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccm_pkg.sv
// Shared types and helpers for the CCM counter-mode XOR data path.
// Holds the pending-payload FIFO entry layout and the last-block byte mask.
package ccm_pkg;

   localparam int WIDTH_KEY   = 128;
   localparam int WIDTH_COUNT = 20;
   localparam int N_BYTES     = WIDTH_KEY / 8;

   typedef struct packed {
      logic [WIDTH_KEY-1:0] data;
      logic                 stream;
      logic                 last;
      logic [3:0]           bytes;
   } fifo_entry_t;

   // Byte 0 sits at the top of the block, so a short last block keeps the upper bytes.
   function automatic logic [WIDTH_KEY-1:0] byte_mask(input logic last, input logic [3:0] bytes);
      logic [WIDTH_KEY-1:0] m;
      m = '1;
      if (last && (bytes != 4'd0)) begin
         for (int i = 0; i < N_BYTES; i++) begin
            if (i >= int'(bytes)) m[WIDTH_KEY-1-8*i -: 8] = 8'h00;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/ccm_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; pointers wrap naturally.
// Push when full and pop when empty are ignored.
module ccm_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [W-1:0]               i_wdata,
   input  logic                       i_pop,
   output logic [W-1:0]               o_rdata,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push_ok;
   logic          w_pop_ok;

   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;

   // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/ccm_ctr_xor.sv
// CCM counter-mode XOR stage: queues payload, requests one counter block per
// payload block, and emits payload ^ keystream with last-block byte masking.
module ccm_ctr_xor #(
   parameter int WIDTH_KEY   = ccm_pkg::WIDTH_KEY,
   parameter int WIDTH_COUNT = ccm_pkg::WIDTH_COUNT,
   parameter int DEPTH       = 4
) (
   input  logic                   clk,
   input  logic                   kill,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH_KEY-1:0]   in_data,
   input  logic                   in_stream_idx,
   input  logic                   in_last,
   input  logic [3:0]             in_bytes,
   output logic                   ctr_req,
   output logic                   ctr_stream_idx,
   input  logic                   ks_en,
   input  logic [WIDTH_KEY-1:0]   ks_data,
   input  logic                   ks_stream_idx,
   output logic                   out_valid,
   output logic [WIDTH_KEY-1:0]   out_data,
   output logic                   out_stream_idx,
   output logic                   out_last,
   output logic [WIDTH_COUNT-1:0] blk_cnt_0,
   output logic [WIDTH_COUNT-1:0] blk_cnt_1,
   output logic                   err_stream,
   output logic                   err_unexp,
   output logic                   err_ovf
);

   import ccm_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   fifo_entry_t          w_wr_entry;
   fifo_entry_t          w_head;
   logic [CW-1:0]        w_count;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_in_ready;
   logic                 w_acc;
   logic                 w_pop;
   logic [WIDTH_KEY-1:0] w_mask;

   logic                   r_out_valid;
   logic [WIDTH_KEY-1:0]   r_out_data;
   logic                   r_out_stream;
   logic                   r_out_last;
   logic [WIDTH_COUNT-1:0] r_blk_cnt_0;
   logic [WIDTH_COUNT-1:0] r_blk_cnt_1;
   logic                   r_err_stream;
   logic                   r_err_unexp;
   logic                   r_err_ovf;

   // Ready depends only on occupancy: a pop in the same cycle never frees a full FIFO early.
   assign w_in_ready = (w_count < CW'(DEPTH));
   assign w_acc      = in_valid & w_in_ready & ~kill;
   assign w_pop      = ks_en & ~w_empty & ~kill;

   assign w_wr_entry = '{data: in_data, stream: in_stream_idx, last: in_last, bytes: in_bytes};

   ccm_sync_fifo #(
      .W     ($bits(fifo_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .i_rst   (kill),
      .i_push  (w_acc),
      .i_wdata (w_wr_entry),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_mask = byte_mask(w_head.last, w_head.bytes);

   always_ff @(posedge clk) begin
      if (kill) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_stream <= 1'b0;
         r_out_last   <= 1'b0;
         r_blk_cnt_0  <= '0;
         r_blk_cnt_1  <= '0;
         r_err_stream <= 1'b0;
         r_err_unexp  <= 1'b0;
         r_err_ovf    <= 1'b0;
      end else begin
         r_out_valid <= w_pop;
         if (w_pop) begin
            r_out_data   <= (w_head.data ^ ks_data) & w_mask;
            r_out_stream <= w_head.stream;
            r_out_last   <= w_head.last;
            if (ks_stream_idx != w_head.stream) r_err_stream <= 1'b1;
            // Counters saturate at all-ones and flag the would-be wrap.
            if (w_head.stream == 1'b0) begin
               if (&r_blk_cnt_0) r_err_ovf   <= 1'b1;
               else              r_blk_cnt_0 <= r_blk_cnt_0 + WIDTH_COUNT'(1);
            end else begin
               if (&r_blk_cnt_1) r_err_ovf   <= 1'b1;
               else              r_blk_cnt_1 <= r_blk_cnt_1 + WIDTH_COUNT'(1);
            end
         end
         if (ks_en && w_empty) r_err_unexp <= 1'b1;
      end
   end

   assign in_ready       = w_in_ready;
   assign ctr_req        = w_acc;
   assign ctr_stream_idx = in_stream_idx;
   assign out_valid      = r_out_valid;
   assign out_data       = r_out_data;
   assign out_stream_idx = r_out_stream;
   assign out_last       = r_out_last;
   assign blk_cnt_0      = r_blk_cnt_0;
   assign blk_cnt_1      = r_blk_cnt_1;
   assign err_stream     = r_err_stream;
   assign err_unexp      = r_err_unexp;
   assign err_ovf        = r_err_ovf;

endmodule

// File: tb/tb_ccm_ctr_xor.sv
// Directed bench for ccm_ctr_xor with a stub counter-encryption stage (ks = ctr_block ^ KEY).
// Uses a 4-bit block counter so saturation is reachable in a few dozen cycles.
module tb_ccm_ctr_xor;

   localparam int WK = 128;
   localparam int WC = 4;
   localparam logic [WK-1:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [WK-1:0] D0   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [WK-1:0] EXP0 = 128'h2b7f17152cabd4a1a3fe1f8305c24133;
   localparam logic [WK-1:0] ONES = '1;

   logic          clk = 1'b0;
   logic          kill = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [WK-1:0] in_data = '0;
   logic          in_stream_idx = 1'b0;
   logic          in_last = 1'b0;
   logic [3:0]    in_bytes = 4'd0;
   logic          ctr_req;
   logic          ctr_stream_idx;
   logic          ks_en;
   logic [WK-1:0] ks_data;
   logic          ks_stream_idx;
   logic          out_valid;
   logic [WK-1:0] out_data;
   logic          out_stream_idx;
   logic          out_last;
   logic [WC-1:0] blk_cnt_0;
   logic [WC-1:0] blk_cnt_1;
   logic          err_stream;
   logic          err_unexp;
   logic          err_ovf;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ccm_ctr_xor #(.WIDTH_KEY(WK), .WIDTH_COUNT(WC), .DEPTH(4)) dut (
      .clk(clk), .kill(kill),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_stream_idx(in_stream_idx), .in_last(in_last), .in_bytes(in_bytes),
      .ctr_req(ctr_req), .ctr_stream_idx(ctr_stream_idx),
      .ks_en(ks_en), .ks_data(ks_data), .ks_stream_idx(ks_stream_idx),
      .out_valid(out_valid), .out_data(out_data), .out_stream_idx(out_stream_idx),
      .out_last(out_last), .blk_cnt_0(blk_cnt_0), .blk_cnt_1(blk_cnt_1),
      .err_stream(err_stream), .err_unexp(err_unexp), .err_ovf(err_ovf)
   );

   // Stub counter stage: in-order keystream after `lat` cycles, shares kill.
   typedef struct { logic s; int due; } req_t;
   req_t          rq[$];
   req_t          cur;
   logic [WK-1:0] cb;
   int            cyc = 0;
   int            lat = 1;
   int            ctr0 = 0;
   int            ctr1 = 0;
   bit            zero_ks = 1'b0;
   bit            flip_stream = 1'b0;
   bit            model_on = 1'b1;
   logic          m_ks_en = 1'b0;
   logic          m_ks_s = 1'b0;
   logic [WK-1:0] m_ks_data = '0;
   logic          f_ks_en = 1'b0;

   assign ks_en         = model_on ? m_ks_en : f_ks_en;
   assign ks_stream_idx = model_on ? m_ks_s : 1'b0;
   assign ks_data       = model_on ? m_ks_data : '0;

   always @(posedge clk) begin
      if (kill) begin
         rq.delete();
         ctr0 = 0;
         ctr1 = 0;
         m_ks_en <= 1'b0;
      end else begin
         if (ctr_req) rq.push_back('{s: ctr_stream_idx, due: cyc + lat - 1});
         if (rq.size() > 0 && rq[0].due <= cyc) begin
            cur = rq.pop_front();
            cb  = (WK'(cur.s) << 20) | WK'(cur.s ? ctr1 : ctr0);
            if (cur.s) ctr1++; else ctr0++;
            m_ks_en   <= 1'b1;
            m_ks_s    <= cur.s ^ flip_stream;
            m_ks_data <= zero_ks ? '0 : (KEY ^ cb);
         end else begin
            m_ks_en <= 1'b0;
         end
      end
      cyc++;
   end

   // Output and request monitors (sample pre-edge values).
   typedef struct { logic [WK-1:0] d; logic s; logic l; } out_t;
   out_t outq[$];
   int   acc_cnt = 0;
   int   acc_at_drop = -1;
   int   n_req_before_ks = 0;
   bit   seen_ks = 1'b0;

   always @(posedge clk) begin
      if (!kill) begin
         if (out_valid) outq.push_back('{d: out_data, s: out_stream_idx, l: out_last});
         if (ks_en) seen_ks = 1'b1;
         if (ctr_req && !seen_ks) n_req_before_ks++;
         if (ctr_req) acc_cnt++;
         if (!in_ready && acc_at_drop < 0) acc_at_drop = acc_cnt;
      end
   end

   task automatic check(input string tag, input logic [WK-1:0] got, input logic [WK-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_kill();
      kill     = 1'b1;
      in_valid = 1'b0;
      f_ks_en  = 1'b0;
      repeat (2) @(negedge clk);
      kill = 1'b0;
      outq.delete();
      acc_cnt         = 0;
      acc_at_drop     = -1;
      n_req_before_ks = 0;
      seen_ks         = 1'b0;
   endtask

   // Presents one block and returns at the negedge after it is accepted.
   task automatic send(input logic s, input logic [WK-1:0] d, input logic l, input logic [3:0] b);
      bit ok;
      in_valid      = 1'b1;
      in_stream_idx = s;
      in_data       = d;
      in_last       = l;
      in_bytes      = b;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         ok = in_ready;
         @(negedge clk);
      end
      if (!ok) check("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_outs(input int n);
      for (int i = 0; i < 100 && outq.size() < n; i++) @(negedge clk);
      check("n_outputs", outq.size(), n);
   endtask

   logic [WK-1:0] b2b_exp [8] = '{128'h0, 128'h100000, 128'h1, 128'h100001,
                                  128'h2, 128'h100002, 128'h3, 128'h100003};

   initial begin
      // Reset values; a request is suppressed while kill is high.
      in_valid = 1'b1;
      in_data  = D0;
      @(negedge clk);
      check("ctr_req_in_kill", ctr_req, 0);
      @(negedge clk);
      kill = 1'b0;
      in_valid = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_meta", {out_stream_idx, out_last}, 0);
      check("rst_cnts", {blk_cnt_0, blk_cnt_1}, 0);
      check("rst_errs", {err_stream, err_unexp, err_ovf}, 0);

      // Single block: request in T, keystream in T+1, output in T+2.
      do_kill();
      in_valid = 1'b1; in_stream_idx = 1'b0; in_data = D0; in_last = 1'b0; in_bytes = 4'd0;
      #1;
      check("single_ctr_req", {ctr_req, ctr_stream_idx}, 2'b10);
      @(negedge clk);
      in_valid = 1'b0;
      check("single_t1_ks_en", ks_en, 1);
      check("single_t1_out_valid", out_valid, 0);
      @(negedge clk);
      check("single_t2_out_valid", out_valid, 1);
      check("single_out_data", out_data, EXP0);
      check("single_out_meta", {out_stream_idx, out_last}, 0);
      check("single_cnts", {blk_cnt_0, blk_cnt_1}, {4'd1, 4'd0});
      @(negedge clk);
      check("single_pulse", out_valid, 0);

      // Back-to-back, alternating streams; data = KEY so output is the counter block.
      do_kill();
      for (int i = 0; i < 8; i++) send(i[0], KEY, 1'b0, 4'd0);
      wait_outs(8);
      for (int i = 0; i < 8 && i < outq.size(); i++) begin
         check($sformatf("b2b_data%0d", i), outq[i].d, b2b_exp[i]);
         check($sformatf("b2b_stream%0d", i), outq[i].s, i[0]);
      end
      check("b2b_cnts", {blk_cnt_0, blk_cnt_1}, {4'd4, 4'd4});
      check("b2b_ready_never_low", acc_at_drop, -1);

      // Backpressure: 6-cycle keystream, 6 blocks offered.
      do_kill();
      lat = 6;
      for (int i = 0; i < 6; i++) send(1'b0, KEY, 1'b0, 4'd0);
      wait_outs(6);
      check("bp_ready_drop_after", acc_at_drop, 4);
      check("bp_req_before_ks", n_req_before_ks, 4);
      check("bp_accepted", acc_cnt, 6);
      if (outq.size() == 6) check("bp_last_data", outq[5].d, 128'h5);
      lat = 1;

      // Last-block masking with a zero keystream.
      do_kill();
      zero_ks = 1'b1;
      send(1'b0, ONES, 1'b1, 4'd5);
      send(1'b0, ONES, 1'b1, 4'd0);
      send(1'b0, ONES, 1'b0, 4'd5);
      wait_outs(3);
      if (outq.size() == 3) begin
         check("mask5_data", outq[0].d, 128'hFFFF_FFFF_FF00_0000_0000_0000_0000_0000);
         check("mask5_last", outq[0].l, 1);
         check("mask0_data", outq[1].d, ONES);
         check("notlast_data", outq[2].d, ONES);
         check("notlast_last", outq[2].l, 0);
      end
      zero_ks = 1'b0;

      // Keystream tagged with the wrong stream.
      do_kill();
      flip_stream = 1'b1;
      send(1'b0, KEY, 1'b0, 4'd0);
      wait_outs(1);
      check("errs_flags", {err_stream, err_unexp, err_ovf}, 3'b100);
      if (outq.size() == 1) check("errs_out_stream", outq[0].s, 0);
      flip_stream = 1'b0;

      // Keystream with nothing pending.
      do_kill();
      model_on = 1'b0;
      f_ks_en  = 1'b1;
      @(negedge clk);
      f_ks_en = 1'b0;
      check("unexp_flag", err_unexp, 1);
      @(negedge clk);
      check("unexp_no_output", out_valid, 0);
      check("unexp_outq", outq.size(), 0);
      model_on = 1'b1;

      // Counter saturation at 4'hF.
      do_kill();
      for (int i = 0; i < 15; i++) send(1'b0, KEY, 1'b0, 4'd0);
      wait_outs(15);
      check("ovf_at_max", {blk_cnt_0, err_ovf}, {4'hF, 1'b0});
      send(1'b0, KEY, 1'b0, 4'd0);
      wait_outs(16);
      check("ovf_hold", {blk_cnt_0, err_ovf}, {4'hF, 1'b1});
      check("ovf_other_cnt", blk_cnt_1, 0);

      // kill with 3 blocks pending, then a fresh block completes normally.
      do_kill();
      model_on = 1'b0;
      f_ks_en  = 1'b1;
      @(negedge clk);
      f_ks_en = 1'b0;
      for (int i = 0; i < 3; i++) send(1'b1, '0, 1'b0, 4'd0);
      check("pend_ready", in_ready, 1);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill_in_ready", in_ready, 1);
      check("kill_out", {out_valid, out_stream_idx, out_last}, 0);
      check("kill_out_data", out_data, 0);
      check("kill_cnts_flags", {blk_cnt_0, blk_cnt_1, err_stream, err_unexp, err_ovf}, 0);
      model_on = 1'b1;
      outq.delete();
      in_valid = 1'b1; in_stream_idx = 1'b0; in_data = D0; in_last = 1'b0; in_bytes = 4'd0;
      @(negedge clk);
      in_valid = 1'b0;
      check("post_kill_t1", out_valid, 0);
      @(negedge clk);
      check("post_kill_t2", out_valid, 1);
      check("post_kill_data", out_data, EXP0);
      repeat (5) @(negedge clk);
      check("post_kill_outq", outq.size(), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
